// File: rtl/sensor_timing_gen_pkg.sv
// Shared types and defaults for the sensor timing generator.
package sensor_tg_pkg;

  localparam int CW_DEF = 12;
  localparam int DW_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    VBLANK,
    VPORCH,
    HACT,
    HBLANK
  } tg_state_e;

  // A zero duration would underflow the down-counter load, so it runs as one cycle.
  function automatic logic [31:0] clamp_to_one(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/sensor_timing_gen_if.sv
// Config/run request and timing outputs of the sensor timing generator.
interface sensor_timing_gen_if
  import sensor_tg_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int DW = DW_DEF
) ();

  logic          enable;
  logic [CW-1:0] v_blank;
  logic [CW-1:0] v_porch;
  logic [CW-1:0] h_act;
  logic [CW-1:0] h_blank;
  logic [CW-1:0] v_lines;
  logic          vsync;
  logic          hsync;
  logic [DW-1:0] pix_data;
  logic          frame_done;
  logic          busy;

  // master: the timing generator itself
  modport master (
    input  enable, v_blank, v_porch, h_act, h_blank, v_lines,
    output vsync, hsync, pix_data, frame_done, busy
  );

  // slave: the controller that configures it and consumes the timing
  modport slave (
    output enable, v_blank, v_porch, h_act, h_blank, v_lines,
    input  vsync, hsync, pix_data, frame_done, busy
  );

endinterface

// File: rtl/sensor_timing_gen.sv
// Programmable vsync/hsync frame timing source with optional test pixel pattern.
// Define PIX_PATTERN_EN to generate pix_data = col + line during active lines.
//
//   state  | meaning
//   IDLE   | stopped, waiting for enable
//   VBLANK | vsync low gap before a frame
//   VPORCH | vsync high, before the first line
//   HACT   | active line, hsync high
//   HBLANK | gap after each line; frame ends here after the last line
module sensor_timing_gen
  import sensor_tg_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic clk,
  input  logic rst_n,
  sensor_timing_gen_if.master bus
);

  localparam logic [CW-1:0] ONE = CW'(1);

  tg_state_e     state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] line;
  logic [CW-1:0] sh_v_porch, sh_h_act, sh_h_blank, sh_v_lines;
  logic          vsync_q, hsync_q, frame_done_q, busy_q;
  logic [CW-1:0] v_blank_c;
  logic          last_line;
  logic          start_frame;

`ifdef PIX_PATTERN_EN
  logic [CW-1:0] col;
  logic [DW-1:0] pix_q;
`endif

  assign v_blank_c   = CW'(clamp_to_one(32'(bus.v_blank)));
  assign last_line   = (line == sh_v_lines - ONE);
  assign start_frame = bus.enable &&
                       ((state == IDLE) ||
                        (state == HBLANK && cnt == '0 && last_line));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      line         <= '0;
      sh_v_porch   <= '0;
      sh_h_act     <= '0;
      sh_h_blank   <= '0;
      sh_v_lines   <= '0;
      vsync_q      <= 1'b0;
      hsync_q      <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef PIX_PATTERN_EN
      col          <= '0;
      pix_q        <= '0;
`endif
    end else begin
      frame_done_q <= 1'b0;
      // v_blank is consumed at the load below, so only the later phases need shadows
      if (start_frame) begin
        sh_v_porch <= CW'(clamp_to_one(32'(bus.v_porch)));
        sh_h_act   <= CW'(clamp_to_one(32'(bus.h_act)));
        sh_h_blank <= CW'(clamp_to_one(32'(bus.h_blank)));
        sh_v_lines <= CW'(clamp_to_one(32'(bus.v_lines)));
      end
      case (state)
        IDLE: begin
          if (bus.enable) begin
            state  <= VBLANK;
            cnt    <= v_blank_c - ONE;
            busy_q <= 1'b1;
          end
        end
        VBLANK: begin
          if (cnt == '0) begin
            state   <= VPORCH;
            cnt     <= sh_v_porch - ONE;
            vsync_q <= 1'b1;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        VPORCH: begin
          if (cnt == '0) begin
            state   <= HACT;
            cnt     <= sh_h_act - ONE;
            hsync_q <= 1'b1;
            line    <= '0;
`ifdef PIX_PATTERN_EN
            col     <= '0;
            pix_q   <= '0;
`endif
          end else begin
            cnt <= cnt - ONE;
          end
        end
        HACT: begin
          if (cnt == '0) begin
            state        <= HBLANK;
            cnt          <= sh_h_blank - ONE;
            hsync_q      <= 1'b0;
            // frame_done is registered, so it is raised one cycle ahead of the last HBLANK cycle
            frame_done_q <= (sh_h_blank == ONE) && last_line;
`ifdef PIX_PATTERN_EN
            pix_q        <= '0;
`endif
          end else begin
            cnt   <= cnt - ONE;
`ifdef PIX_PATTERN_EN
            col   <= col + ONE;
            pix_q <= DW'(col + ONE + line);
`endif
          end
        end
        HBLANK: begin
          if (cnt == '0) begin
            if (!last_line) begin
              state   <= HACT;
              cnt     <= sh_h_act - ONE;
              hsync_q <= 1'b1;
              line    <= line + ONE;
`ifdef PIX_PATTERN_EN
              col     <= '0;
              pix_q   <= DW'(line + ONE);
`endif
            end else begin
              vsync_q <= 1'b0;
              if (bus.enable) begin
                state <= VBLANK;
                cnt   <= v_blank_c - ONE;
              end else begin
                state  <= IDLE;
                busy_q <= 1'b0;
              end
            end
          end else begin
            cnt          <= cnt - ONE;
            frame_done_q <= (cnt == ONE) && last_line;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.vsync      = vsync_q;
  assign bus.hsync      = hsync_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = busy_q;
`ifdef PIX_PATTERN_EN
  assign bus.pix_data   = pix_q;
`else
  assign bus.pix_data   = {DW{1'b0}};
`endif

endmodule
